// File: rtl/fifo_pkg.sv
// Shared FIFO constants: read-mode encodings and width helpers.
package fifo_pkg;

   localparam int unsigned FWFT_MODE_REG  = 0;
   localparam int unsigned FWFT_MODE_FALL = 1;

   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? int'($clog2(depth)) : 1;
   endfunction

   // One extra bit so a completely full FIFO is representable.
   function automatic int unsigned count_width(input int unsigned depth);
      return int'($clog2(depth)) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_ram #(
   parameter int unsigned SIZE_DATA  = 8,
   parameter int unsigned SIZE_DEPTH = 16,
   parameter int unsigned SIZE_ADDR  = 4
) (
   input  logic                 i_clk,
   input  logic                 i_wr_en,
   input  logic [SIZE_ADDR-1:0] i_wr_addr,
   input  logic [SIZE_DATA-1:0] i_wr_data,
   input  logic [SIZE_ADDR-1:0] i_rd_addr,
   output logic [SIZE_DATA-1:0] o_rd_data_c
);

   logic [SIZE_DATA-1:0] mem [SIZE_DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data_c = mem[i_rd_addr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds
// and selectable registered-read or first-word-fall-through output.
module fifo_sync_prog
   import fifo_pkg::*;
#(
   parameter int unsigned SIZE_DATA     = 8,
   parameter int unsigned SIZE_DEPTH    = 16,
   parameter int unsigned AFULL_THRESH  = SIZE_DEPTH - 2,
   parameter int unsigned AEMPTY_THRESH = 2,
   parameter int unsigned FWFT_EN       = FWFT_MODE_REG
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic                                i_wr_en,
   input  logic                                i_rd_en,
   input  logic [SIZE_DATA-1:0]                i_data,
   output logic [SIZE_DATA-1:0]                o_data,
   output logic                                o_full,
   output logic                                o_empty,
   output logic                                o_almost_full,
   output logic                                o_almost_empty,
   output logic [count_width(SIZE_DEPTH)-1:0]  o_count,
   output logic                                o_overflow,
   output logic                                o_underflow
);

   localparam int unsigned SIZE_ADDR  = addr_width(SIZE_DEPTH);
   localparam int unsigned SIZE_COUNT = count_width(SIZE_DEPTH);

   // Reject illegal parameterisations at elaboration.
   if (SIZE_DATA < 1 || SIZE_DATA > 64) begin : g_bad_data
      $fatal(1, "fifo_sync_prog: SIZE_DATA must be 1..64");
   end
   if (SIZE_DEPTH < 4 || (SIZE_DEPTH & (SIZE_DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "fifo_sync_prog: SIZE_DEPTH must be a power of two >= 4");
   end
   if (AFULL_THRESH < 1 || AFULL_THRESH > SIZE_DEPTH) begin : g_bad_afull
      $fatal(1, "fifo_sync_prog: AFULL_THRESH must be 1..SIZE_DEPTH");
   end
   if (AEMPTY_THRESH > SIZE_DEPTH - 1) begin : g_bad_aempty
      $fatal(1, "fifo_sync_prog: AEMPTY_THRESH must be 0..SIZE_DEPTH-1");
   end
   if (FWFT_EN != FWFT_MODE_REG && FWFT_EN != FWFT_MODE_FALL) begin : g_bad_fwft
      $fatal(1, "fifo_sync_prog: FWFT_EN must be 0 or 1");
   end

   logic [SIZE_ADDR-1:0]  ptr_wr_q, ptr_wr_d;
   logic [SIZE_ADDR-1:0]  ptr_rd_q, ptr_rd_d;
   logic [SIZE_COUNT-1:0] count_q, count_d;
   logic [SIZE_DATA-1:0]  data_q, data_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic                  full_c, empty_c, wr_ok_c, rd_ok_c;
   logic [SIZE_DATA-1:0]  ram_rd_data_c;

   assign full_c  = (count_q == SIZE_COUNT'(SIZE_DEPTH));
   assign empty_c = (count_q == '0);
   // A read frees a slot, so a full FIFO may still take a write alongside it.
   assign rd_ok_c = i_rd_en && !empty_c;
   assign wr_ok_c = i_wr_en && (!full_c || rd_ok_c);

   fifo_ram #(
      .SIZE_DATA  (SIZE_DATA),
      .SIZE_DEPTH (SIZE_DEPTH),
      .SIZE_ADDR  (SIZE_ADDR)
   ) u_ram (
      .i_clk       (i_clk),
      .i_wr_en     (wr_ok_c),
      .i_wr_addr   (ptr_wr_q),
      .i_wr_data   (i_data),
      .i_rd_addr   (ptr_rd_q),
      .o_rd_data_c (ram_rd_data_c)
   );

   // Next-state for pointers, count, read data and error pulses.
   always_comb begin
      ptr_wr_d    = ptr_wr_q;
      ptr_rd_d    = ptr_rd_q;
      count_d     = count_q;
      data_d      = data_q;
      overflow_d  = i_wr_en && !wr_ok_c;
      underflow_d = i_rd_en && empty_c;
      if (wr_ok_c) ptr_wr_d = ptr_wr_q + SIZE_ADDR'(1);
      if (rd_ok_c) ptr_rd_d = ptr_rd_q + SIZE_ADDR'(1);
      case ({wr_ok_c, rd_ok_c})
         2'b10:   count_d = count_q + SIZE_COUNT'(1);
         2'b01:   count_d = count_q - SIZE_COUNT'(1);
         default: count_d = count_q;
      endcase
      if (rd_ok_c && FWFT_EN == FWFT_MODE_REG) data_d = ram_rd_data_c;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         ptr_wr_q    <= '0;
         ptr_rd_q    <= '0;
         count_q     <= '0;
         data_q      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         ptr_wr_q    <= ptr_wr_d;
         ptr_rd_q    <= ptr_rd_d;
         count_q     <= count_d;
         data_q      <= data_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign o_data         = (FWFT_EN == FWFT_MODE_FALL) ? ram_rd_data_c : data_q;
   assign o_full         = full_c;
   assign o_empty        = empty_c;
   assign o_almost_full  = (count_q >= SIZE_COUNT'(AFULL_THRESH));
   assign o_almost_empty = (count_q <= SIZE_COUNT'(AEMPTY_THRESH));
   assign o_count        = count_q;
   assign o_overflow     = overflow_q;
   assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: a registered-read and a FWFT instance share
// stimulus and are compared against a queue-based reference.
module tb_fifo_sync_prog;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AF    = 14;
   localparam int unsigned AE    = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] din = '0;

   logic [DW-1:0] r_data, f_data;
   logic          r_full, r_empty, r_af, r_ae, r_ov, r_un;
   logic          f_full, f_empty, f_af, f_ae, f_ov, f_un;
   logic [4:0]    r_count, f_count;

   always #5 clk = ~clk;

   fifo_sync_prog #(.SIZE_DATA(DW), .SIZE_DEPTH(DEPTH), .AFULL_THRESH(AF),
                    .AEMPTY_THRESH(AE), .FWFT_EN(0)) dut_reg (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_rd_en(rd_en), .i_data(din),
      .o_data(r_data), .o_full(r_full), .o_empty(r_empty), .o_almost_full(r_af),
      .o_almost_empty(r_ae), .o_count(r_count), .o_overflow(r_ov), .o_underflow(r_un));

   fifo_sync_prog #(.SIZE_DATA(DW), .SIZE_DEPTH(DEPTH), .AFULL_THRESH(AF),
                    .AEMPTY_THRESH(AE), .FWFT_EN(1)) dut_fwft (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_rd_en(rd_en), .i_data(din),
      .o_data(f_data), .o_full(f_full), .o_empty(f_empty), .o_almost_full(f_af),
      .o_almost_empty(f_ae), .o_count(f_count), .o_overflow(f_ov), .o_underflow(f_un));

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Reference state
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_rdata = '0;
   logic          m_ov = 1'b0;
   logic          m_un = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      else
         n_pass++;
   endtask

   // Apply one cycle of stimulus, advance the reference, then compare both DUTs.
   task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic rn);
      logic was_empty, was_full, rd_ok, wr_ok;
      int sz;
      rst_n = rn; wr_en = w; rd_en = r; din = d;
      was_empty = (q.size() == 0);
      was_full  = (q.size() == DEPTH);
      if (!rn) begin
         q.delete();
         m_rdata = '0; m_ov = 1'b0; m_un = 1'b0;
      end else begin
         rd_ok = r && !was_empty;
         wr_ok = w && (!was_full || rd_ok);
         m_ov  = w && !wr_ok;
         m_un  = r && was_empty;
         if (rd_ok) m_rdata = q.pop_front();
         if (wr_ok) q.push_back(d);
      end
      @(posedge clk);
      #1;
      cyc++;
      sz = q.size();
      chk("count",      64'(r_count), 64'(sz));
      chk("full",       64'(r_full),  64'(sz == DEPTH));
      chk("empty",      64'(r_empty), 64'(sz == 0));
      chk("almost_full",  64'(r_af),  64'(sz >= AF));
      chk("almost_empty", 64'(r_ae),  64'(sz <= AE));
      chk("overflow",   64'(r_ov),    64'(m_ov));
      chk("underflow",  64'(r_un),    64'(m_un));
      chk("reg_data",   64'(r_data),  64'(m_rdata));
      chk("fwft_count", 64'(f_count), 64'(sz));
      chk("fwft_ovf_unf", 64'({f_ov, f_un}), 64'({m_ov, m_un}));
      if (sz > 0) chk("fwft_data", 64'(f_data), 64'(q[0]));
   endtask

   initial begin
      logic [DW-1:0] rv;
      // Reset, then idle
      step(0, 0, '0, 0);
      step(0, 0, '0, 0);
      step(0, 0, '0, 1);
      chk("idle_data_zero", 64'(r_data), 64'h0);
      chk("idle_empty", 64'(r_empty), 64'h1);

      // Overfill with 17 random words
      for (int i = 0; i < 17; i++) step(1, 0, DW'($urandom), 1);
      chk("overfill_count", 64'(r_count), 64'd16);
      // Drain with 17 reads; last one underflows
      for (int i = 0; i < 17; i++) step(0, 1, '0, 1);
      chk("drained_empty", 64'(r_empty), 64'h1);

      // Fill, then simultaneous write 8'hA5 + read while full
      for (int i = 0; i < 16; i++) step(1, 0, DW'($urandom), 1);
      step(1, 1, 8'hA5, 1);
      chk("full_rw_count", 64'(r_count), 64'd16);
      for (int i = 0; i < 16; i++) step(0, 1, '0, 1);
      chk("a5_read_last", 64'(r_data), 64'hA5);

      // FWFT: single word into empty FIFO appears without a read
      step(1, 0, 8'h29, 1);
      chk("fwft_fall_through", 64'(f_data), 64'h29);
      step(0, 1, '0, 1);
      chk("fwft_empty_after", 64'(f_empty), 64'h1);

      // Reset mid-stream with a concurrent write
      for (int i = 0; i < 5; i++) step(1, 0, DW'($urandom), 1);
      step(1, 0, 8'h77, 0);
      chk("rst_override_count", 64'(r_count), 64'd0);
      step(1, 0, 8'h3C, 1);
      step(0, 1, '0, 1);
      chk("post_rst_data", 64'(r_data), 64'h3C);

      // Random traffic with occasional resets and biased fill/drain phases
      for (int i = 0; i < 600; i++) begin
         int bias;
         bias = (i / 100) % 3;
         rv = DW'($urandom);
         step(($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 2 : 5))),
              ($urandom_range(0, 9) < (bias == 0 ? 2 : (bias == 1 ? 8 : 5))),
              rv, ($urandom_range(0, 99) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_sync_prog.md
FIFO_SYNC_PROG -- requirements
Module: fifo_sync_prog

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 8: data word width in bits, legal values 1..64.
REQ-002 SHALL have parameter SIZE_DEPTH, default 16: number of entries, a power of two, at least 4.
REQ-003 SHALL have parameter AFULL_THRESH, default SIZE_DEPTH-2: o_almost_full asserts at or above this count, legal 1..SIZE_DEPTH.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 2: o_almost_empty asserts at or below this count, legal 0..SIZE_DEPTH-1.
REQ-005 SHALL have parameter FWFT_EN, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock, rising-edge active.
REQ-007 SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port i_wr_en, input, 1 bit: write request.
REQ-009 SHALL have port i_rd_en, input, 1 bit: read request.
REQ-010 SHALL have port i_data, input, SIZE_DATA bits: write data.
REQ-011 SHALL have port o_data, output, SIZE_DATA bits: read data.
REQ-012 SHALL have ports o_full and o_empty, output, 1 bit each: occupancy equals SIZE_DEPTH, and occupancy equals 0.
REQ-013 SHALL have ports o_almost_full and o_almost_empty, output, 1 bit each: programmable threshold flags.
REQ-014 SHALL have port o_count, output, $clog2(SIZE_DEPTH)+1 bits: current occupancy.
REQ-015 SHALL have ports o_overflow and o_underflow, output, 1 bit each: error pulses.

Function
REQ-016 SHALL accept a write in a cycle iff i_wr_en=1 and either o_full=0 or a read is accepted in the same cycle.
REQ-017 SHALL accept a read in a cycle iff i_rd_en=1 and o_empty=0; a simultaneous write SHALL NOT make a read from an empty FIFO legal.
REQ-018 SHALL, on an accepted write, store i_data at ptr_wr and advance ptr_wr by 1 modulo SIZE_DEPTH; on an accepted read, SHALL advance ptr_rd likewise.
REQ-019 SHALL update o_count at each clock edge: +1 on write only, -1 on read only, unchanged on both or neither; o_count SHALL never exceed SIZE_DEPTH or go below 0.
REQ-020 SHALL derive o_full, o_empty, o_almost_full and o_almost_empty combinationally from the registered count: o_almost_full = (count >= AFULL_THRESH) and o_almost_empty = (count <= AEMPTY_THRESH).
REQ-021 SHALL, when FWFT_EN=0, register the word at ptr_rd into o_data on an accepted read, so the data appears one cycle after the read edge; o_data SHALL hold its value otherwise.
REQ-022 SHALL, when FWFT_EN=1, drive o_data with the word at ptr_rd whenever o_empty=0, with zero read latency; an accepted read SHALL expose the next word after the edge; o_data is don't-care while empty.
REQ-023 SHALL pulse o_overflow high for exactly one cycle, in the cycle after an edge where i_wr_en=1 and the write was rejected; storage, ptr_wr and count SHALL be unchanged.
REQ-024 SHALL pulse o_underflow high for exactly one cycle, in the cycle after an edge where i_rd_en=1 and o_empty=1; ptr_rd, count and o_data SHALL be unchanged.
REQ-025 SHALL treat a write and a read when full as both accepted: count stays SIZE_DEPTH, both pointers advance, and there is no overflow.

Reset
REQ-026 SHALL, on a clock edge with i_rst_n=0, set ptr_wr, ptr_rd, count, o_data, o_overflow and o_underflow to 0, giving o_empty=1, o_full=0 and o_almost_empty=1.
REQ-027 SHALL let reset override any simultaneous read or write, including mid-stream; memory contents need not be cleared.

Structure
REQ-028 SHALL place shared FIFO constants in package fifo_pkg: the count and address width helper functions and the FWFT mode encodings.
REQ-029 SHALL instantiate one sub-module, fifo_ram: a simple dual-port array with a synchronous write and an asynchronous read address, with no reset.
REQ-030 SHALL check parameter legality at elaboration: power-of-two depth, and thresholds within the legal range.

Verification (SIZE_DATA=8, SIZE_DEPTH=16, AFULL=14, AEMPTY=2)
REQ-031 Reset then idle -> o_empty=1, o_full=0, o_count=0, o_almost_empty=1, o_data=8'h00.
REQ-032 Write 17 random words, FWFT_EN=0 -> o_almost_full at count 14, o_full at count 16, one o_overflow pulse on the 17th, o_count=16.
REQ-033 Read 17 times -> 16 words in write order, each appearing one cycle after its read edge; o_empty at count 0; one o_underflow pulse; o_data holds the 16th word.
REQ-034 When full, write 8'hA5 with a simultaneous read -> oldest word returned, o_count stays 16, no overflow, and 8'hA5 is read last.
REQ-035 FWFT_EN=1, write 8'h29 into an empty FIFO -> o_data=8'h29 in the cycle after the write edge, before any read; reading it gives o_empty=1.
REQ-036 Write 5 words, then assert i_rst_n=0 for one edge with i_wr_en=1 -> o_count=0 and pointers at 0; a following write and read returns the new data.
